// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- multi-cycle execute unit between the control unit and the
// register file.
//
// Logic, add, shift and pass-through operations complete in one cycle. MUL is
// an iterative shift-add multiplier (LSB first, 32-bit accumulator). DIV is an
// iterative restoring divider (MSB first, 17-bit partial remainder).
//
// Configuration macro:
//   ALU_DIVIDER_EN  defined   -> iterative divider is built; DIV by zero gives
//                                0xFFFF with div_by_zero set, single-cycle.
//                   undefined -> no divider hardware; DIV is a single-cycle op
//                                returning 0 with div_by_zero clear.
//
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   start        in   1      one-cycle request, accepted only in IDLE
//   alu_sel      in   4      operation code
//   op_a         in   WIDTH  rs operand
//   op_b         in   WIDTH  rt operand or zero-extended immediate
//   busy         out  1      high from the cycle after acceptance until done
//   done         out  1      one-cycle pulse, result valid in the same cycle
//   result       out  WIDTH  operation result, held until the next done
//   zero_flag    out  1      result == 0, updated on done
//   pos_flag     out  1      result > 0 as a signed value, updated on done
//   div_by_zero  out  1      DIV with op_b == 0, updated on done
//
// Handshake: start is a request sampled on a rising edge only while the FSM
// is IDLE; there is no ready signal, so a start seen while busy (including the
// done cycle) is dropped, not queued. done is the single-cycle response, and
// result plus flags are registered on the same edge that raises done.
// -----------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             pos_flag,
    output logic             div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_LD  = 4'd9;
    localparam logic [3:0] OP_ST  = 4'd10;
    localparam logic [3:0] OP_MOV = 4'd11;

    localparam int              CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]   mcand;
    // MUL: {partial product, remaining multiplier bits}.
    // DIV: low half holds the dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0] acc;
`ifdef ALU_DIVIDER_EN
    logic [WIDTH:0]     rem;
    logic               is_div;
`endif

    // ---------------- single-cycle datapath (from live inputs) -------------
    logic [WIDTH-1:0] quick_res;
    logic             quick_dbz;
    logic             goes_iter;

    always_comb begin
        quick_res = '0;
        case (alu_sel)
            OP_ADD: quick_res = op_a + op_b;
            OP_SUB: quick_res = op_a - op_b;
`ifdef ALU_DIVIDER_EN
            // Only reached here when op_b is zero; nonzero divisors iterate.
            OP_DIV: quick_res = '1;
`else
            OP_DIV: quick_res = '0;
`endif
            OP_AND: quick_res = op_a & op_b;
            OP_OR:  quick_res = op_a | op_b;
            OP_XOR: quick_res = op_a ^ op_b;
            // Shift amount is b[4:0]; 16..31 shifts everything out.
            OP_LSL: quick_res = op_b[4] ? '0 : (op_a << op_b[3:0]);
            OP_LSR: quick_res = op_b[4] ? '0 : (op_a >> op_b[3:0]);
            OP_LD, OP_ST, OP_MOV: quick_res = op_b;
            default: quick_res = '0;
        endcase
    end

    always_comb begin
`ifdef ALU_DIVIDER_EN
        quick_dbz = (alu_sel == OP_DIV) && (op_b == '0);
        goes_iter = (alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && (op_b != '0));
`else
        quick_dbz = 1'b0;
        goes_iter = (alu_sel == OP_MUL);
`endif
    end

    // ---------------- iterative datapath ----------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef ALU_DIVIDER_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;

    always_comb begin
        div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        rem_next  = div_ge ? (div_shift - {1'b0, mcand}) : div_shift;
        quot_next = {acc[WIDTH-2:0], div_ge};
    end
`endif

    logic [WIDTH-1:0] iter_res;

    always_comb begin
`ifdef ALU_DIVIDER_EN
        iter_res = is_div ? quot_next : mul_next[WIDTH-1:0];
`else
        iter_res = mul_next[WIDTH-1:0];
`endif
    end

    // ---------------- control ----------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mcand       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            zero_flag   <= 1'b0;
            pos_flag    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef ALU_DIVIDER_EN
            rem         <= '0;
            is_div      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (goes_iter) begin
                            state <= ST_CALC;
                            cnt   <= '0;
                            mcand <= op_b;
                            acc   <= {{WIDTH{1'b0}}, op_a};
`ifdef ALU_DIVIDER_EN
                            rem    <= '0;
                            is_div <= (alu_sel == OP_DIV);
`endif
                        end else begin
                            state       <= ST_FIN;
                            done        <= 1'b1;
                            result      <= quick_res;
                            zero_flag   <= (quick_res == '0);
                            pos_flag    <= !quick_res[WIDTH-1] && (quick_res != '0);
                            div_by_zero <= quick_dbz;
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
`ifdef ALU_DIVIDER_EN
                    if (is_div) begin
                        acc[WIDTH-1:0] <= quot_next;
                        rem            <= rem_next;
                    end else begin
                        acc <= mul_next;
                    end
`else
                    acc <= mul_next;
`endif
                    // The last iteration's combinational result is captured
                    // directly so done rises on the edge that ends CALC.
                    if (cnt == CNT_LAST) begin
                        state       <= ST_FIN;
                        done        <= 1'b1;
                        result      <= iter_res;
                        zero_flag   <= (iter_res == '0);
                        pos_flag    <= !iter_res[WIDTH-1] && (iter_res != '0);
                        div_by_zero <= 1'b0;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec.
// Directed table of vectors, hand-written corner sequences (start during CALC,
// start during the done cycle, reset mid-operation), then random operations
// checked against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_exec;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MUL = 4'd2,  DIV = 4'd3;
    localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5,  XOR_ = 4'd6, LSL = 4'd7;
    localparam logic [3:0] LSR = 4'd8,  LD = 4'd9,   ST = 4'd10,  MOV = 4'd11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_sel = 4'd0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        busy, done, zero_flag, pos_flag, div_by_zero;
    logic [15:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec #(.WIDTH(16), .ITER(16)) dut (
        .clock(clock), .reset(reset), .start(start), .alu_sel(alu_sel),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .zero_flag(zero_flag), .pos_flag(pos_flag), .div_by_zero(div_by_zero)
    );

    // ---------------- clock / reset ----------------------------------------
    always #5 clock = ~clock;

    // ---------------- scoreboard helpers -----------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions, using wide arithmetic.
    function automatic void ref_model(input logic [3:0] sel, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic dz, output int lat);
        longint ua, ub, amt;
        ua  = longint'(a);
        ub  = longint'(b);
        amt = ub % 32;
        r   = 16'd0;
        dz  = 1'b0;
        lat = 1;
        case (sel)
            ADD:  r = 16'((ua + ub) % 65536);
            SUB:  r = 16'((ua - ub + 65536) % 65536);
            MUL:  begin r = 16'((ua * ub) % 65536); lat = 17; end
            DIV: begin
`ifdef ALU_DIVIDER_EN
                if (ub == 0) begin r = 16'hFFFF; dz = 1'b1; end
                else begin r = 16'(ua / ub); lat = 17; end
`else
                r = 16'd0;
`endif
            end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            LSL:  r = (amt >= 16) ? 16'd0 : 16'((ua * (longint'(1) << amt)) % 65536);
            LSR:  r = (amt >= 16) ? 16'd0 : 16'(ua / (longint'(1) << amt));
            LD, ST, MOV: r = b;
            default: r = 16'd0;
        endcase
    endfunction

    // ---------------- driver ------------------------------------------------
    // Issues one operation from an idle DUT and checks the full response.
    // poke_calc: pulse a conflicting start during the iteration phase.
    // poke_fin:  pulse a start during the done cycle.
    task automatic run_op(input string tag, input logic [3:0] sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ez,
                          input logic ep, input logic ed, input int el,
                          input bit poke_calc, input bit poke_fin);
        int lat;
        bit busy_ok;
        @(negedge clock);
        start = 1'b1; alu_sel = sel; op_a = a; op_b = b;
        @(posedge clock); #1;
        // Inputs after acceptance must not matter.
        start = 1'b0; alu_sel = 4'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke_calc && lat == 5) begin
                start = 1'b1; alu_sel = ADD; op_a = 16'h1111; op_b = 16'h2222;
            end
            @(posedge clock); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " busy"}, 32'(busy_ok && busy === 1'b1), 32'd1);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " zero_flag"}, 32'(zero_flag), 32'(ez));
        check({tag, " pos_flag"}, 32'(pos_flag), 32'(ep));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ed));
        if (poke_fin) begin
            start = 1'b1; alu_sel = ADD; op_a = 16'h0001; op_b = 16'h0001;
        end
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
        if (poke_fin) begin
            @(posedge clock); #1;
            check({tag, " start in done cycle ignored"}, {30'd0, busy, done}, 32'd0);
            check({tag, " result held"}, 32'(result), 32'(er));
        end
    endtask

    task automatic run_model_op(input string tag, input logic [3:0] sel,
                                input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic dz;
        int lat;
        ref_model(sel, a, b, r, dz, lat);
        run_op(tag, sel, a, b, r, (r == 16'd0), (r != 16'd0 && r < 16'h8000), dz, lat, 1'b0, 1'b0);
    endtask

    // ---------------- directed vectors -------------------------------------
    typedef struct {
        string       name;
        logic [3:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        p;
        logic        dz;
        int          lat;
        bit          poke_calc;
        bit          poke_fin;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(string name, logic [3:0] sel, logic [15:0] a, logic [15:0] b,
                                    logic [15:0] res, logic z, logic p, logic dz, int lat,
                                    bit pc, bit pf);
        vec_t v;
        v.name = name; v.sel = sel; v.a = a; v.b = b; v.res = res;
        v.z = z; v.p = p; v.dz = dz; v.lat = lat; v.poke_calc = pc; v.poke_fin = pf;
        vecs.push_back(v);
    endfunction

    // ---------------- main sequence ----------------------------------------
    initial begin
        bit seen;

        add_vec("add_7fff_1",   ADD,  16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 1,  0, 0);
        add_vec("sub_equal",    SUB,  16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("lsl_by_16",    LSL,  16'h0001, 16'd16,   16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("mul_123_45",   MUL,  16'h0123, 16'h0045, 16'h4E6F, 0, 1, 0, 17, 0, 0);
        add_vec("mul_ffff_sq",  MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 0, 1, 0, 17, 0, 0);
        add_vec("mul_poked",    MUL,  16'h0123, 16'h0045, 16'h4E6F, 0, 1, 0, 17, 1, 0);
        add_vec("sub_wrap",     SUB,  16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 1,  0, 0);
        add_vec("and",          AND_, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 1, 0, 1,  0, 0);
        add_vec("or",           OR_,  16'h8000, 16'h0001, 16'h8001, 0, 0, 0, 1,  0, 1);
        add_vec("xor_self",     XOR_, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("lsl_4",        LSL,  16'h0003, 16'd4,    16'h0030, 0, 1, 0, 1,  0, 0);
        add_vec("lsl_amt_0x20", LSL,  16'h00FF, 16'h0020, 16'h00FF, 0, 1, 0, 1,  0, 0);
        add_vec("lsr_15",       LSR,  16'h8000, 16'd15,   16'h0001, 0, 1, 0, 1,  0, 0);
        add_vec("lsr_17",       LSR,  16'hFFFF, 16'd17,   16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("ld",           LD,   16'h1234, 16'h0042, 16'h0042, 0, 1, 0, 1,  0, 0);
        add_vec("st_zero",      ST,   16'h1234, 16'h0000, 16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("mov",          MOV,  16'h1234, 16'hABCD, 16'hABCD, 0, 0, 0, 1,  0, 0);
        add_vec("op12",         4'd12, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 1, 0, 0);
        add_vec("op15",         4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0, 1, 0, 0);
`ifdef ALU_DIVIDER_EN
        add_vec("div_1000_7",   DIV,  16'd1000,   16'd7,    16'd142,  0, 1, 0, 17, 0, 0);
        add_vec("div_by_zero",  DIV,  16'd1000,   16'd0,    16'hFFFF, 0, 0, 1, 1,  0, 0);
`else
        add_vec("div_1000_7",   DIV,  16'd1000,   16'd7,    16'h0000, 1, 0, 0, 1,  0, 0);
        add_vec("div_by_zero",  DIV,  16'd1000,   16'd0,    16'h0000, 1, 0, 0, 1,  0, 0);
`endif
        add_vec("mov_nonzero",  MOV,  16'h0000, 16'h5A5A, 16'h5A5A, 0, 1, 0, 1,  0, 0);

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", {29'd0, zero_flag, pos_flag, div_by_zero}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].z, vecs[i].p, vecs[i].dz, vecs[i].lat,
                   vecs[i].poke_calc, vecs[i].poke_fin);

        // Reset in the middle of an iterative operation aborts it silently.
        @(negedge clock);
`ifdef ALU_DIVIDER_EN
        start = 1'b1; alu_sel = DIV; op_a = 16'd1000; op_b = 16'd7;
`else
        start = 1'b1; alu_sel = MUL; op_a = 16'h0123; op_b = 16'h0045;
`endif
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clock); #1;
        end
        check("abort busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort outputs cleared",
              {13'd0, busy, done, zero_flag, pos_flag, div_by_zero, result[13:0]}, 32'd0);
        check("abort result high bits", 32'(result[15:14]), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort no done", 32'(seen), 32'd0);

        run_op("add_3_4", ADD, 16'd3, 16'd4, 16'd7, 0, 1, 0, 1, 0, 0);
        run_model_op("div_after_abort", DIV, 16'd1000, 16'd7);

        // Random operations against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  sel;
            logic [15:0] a, b;
            sel = 4'($urandom_range(0, 15));
            a   = 16'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            run_model_op($sformatf("rand%0d_sel%0d", n, sel), sel, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
